uart_print_ctrl: RTL and testbench
==================================

UART_PRINT_CTRL -- requirements
Module: uart_print_ctrl

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the UART; legal range 2..8.
REQ-002 Parameter EOL_CRLF, default 1: 1 terminates each frame with CR LF (0x0D 0x0A); 0 terminates with LF only.
REQ-003 I_clk  input  1  sole clock; all logic on its rising edge; uart byte transmitter shares this clock.
REQ-004 I_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 I_req  input  N_REQ  per-requester print request, level, held until acknowledged.
REQ-006 I_tag  input  8*N_REQ  per-requester ASCII tag character, slice k = [8k+7:8k].
REQ-007 I_value  input  32*N_REQ  per-requester value to print, slice k = [32k+31:32k].
REQ-008 O_ack  output  N_REQ  one-cycle grant pulse to the selected requester.
REQ-009 O_tx_data  output  8  byte to the uart byte transmitter.
REQ-010 O_tx_valid  output  1  O_tx_data valid.
REQ-011 I_tx_ready  input  1  transmitter accepts byte on a cycle with O_tx_valid=1.
REQ-012 O_busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Frame = tag, ':' (0x3A), 8 hex digits of latched value MSB nibble first, then EOL; 12 bytes with EOL_CRLF=1, 11 with EOL_CRLF=0.
REQ-014 Hex digits are uppercase ASCII: nibble 0-9 -> 0x30+n, A-F -> 0x41+(n-10).
REQ-015 States: IDLE, SEND. IDLE -> SEND when any I_req bit is high; SEND -> IDLE on the cycle the last frame byte is accepted.
REQ-016 Arbitration is round-robin: search starts at the index one above the last granted index, wrapping modulo N_REQ; after reset the search starts at index 0.
REQ-017 On the IDLE -> SEND edge, the granted requester's tag and value are latched, O_ack[k] is high for exactly the following cycle, and the round-robin pointer is updated.
REQ-018 Latency: with a request present at IDLE edge N, O_tx_valid=1 with the tag byte from cycle N+1.
REQ-019 A byte advances only on an edge where O_tx_valid=1 and I_tx_ready=1; O_tx_data shall not change while O_tx_valid=1 and I_tx_ready=0.
REQ-020 With I_tx_ready held high, bytes are presented on consecutive cycles with no bubbles inside a frame.
REQ-021 After the last byte is accepted, O_tx_valid is low for at least one cycle (IDLE) before the next frame's tag byte.
REQ-022 Changes on I_value/I_tag after grant do not affect the frame in progress.
REQ-023 A request deasserted before its O_ack is dropped silently; requests arriving during SEND wait, and are not lost while held.
REQ-024 The byte index counter wraps only through IDLE; it never exceeds frame length minus 1.
REQ-025 Simultaneous requests from all N_REQ requesters are serviced in N_REQ consecutive frames, each requester once, in round-robin order.

Reset
REQ-026 While I_rst_n=0: state IDLE, O_ack=0, O_tx_valid=0, O_tx_data=0x00, O_busy=0, byte index 0, round-robin pointer selects index 0, latched tag/value 0.
REQ-027 Reset asserted mid-frame abandons the frame immediately (O_tx_valid falls asynchronously); no partial frame resumes after release.
REQ-028 First grant is possible on the first rising edge after I_rst_n deasserts.

Structure
REQ-029 Package uart_print_pkg holds ASCII constants (colon, CR, LF, '0', 'A'), state encoding, and frame-length constants.
REQ-030 Sub-module rr_arbiter (N_REQ requests, pointer in, one-hot grant out, combinational) contains the round-robin selection; sequencing, latching and hex formatting stay in uart_print_ctrl.

Verification
REQ-031 Single request: I_req=4'b0001, tag 0x46 'F', value 0x00C0FFEE, ready always 1 -> bytes 46 3A 30 30 43 30 46 46 45 45 0D 0A on 12 consecutive cycles, ack[0] one cycle.
REQ-032 All-request contention: I_req=4'b1111 held, values distinct -> frames in order 0,1,2,3, then 0 again; each ack a single pulse; one idle cycle between frames.
REQ-033 Backpressure: I_tx_ready toggling 1,0,0,1,... during value 0x12345678 -> O_tx_data stable while stalled; stream still 31 32 33 34 35 36 37 38 after tag/colon.
REQ-034 Value change after grant: I_value[0] switches 0xAAAAAAAA -> 0x55555555 two cycles after ack -> all 8 digits transmitted as 0x41.
REQ-035 Reset mid-frame: assert I_rst_n=0 after 5th byte -> O_tx_valid=0 immediately; after release with req held, a fresh frame starts with the tag byte.
REQ-036 EOL_CRLF=0 and value 0xFFFFFFFF -> 11-byte frame ending 46 46 0A.

Source files
------------

// File: rtl/uart_print_pkg.sv
// Shared constants for the UART print controller: ASCII codes, state
// encoding, frame layout and the nibble-to-hex helper.
package uart_print_pkg;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  // Frame layout: [0] tag, [1] ':', [2..9] hex digits, [10..] EOL
  localparam int FRAME_LEN_CRLF = 12;
  localparam int FRAME_LEN_LF   = 11;
  localparam logic [3:0] IDX_TAG       = 4'd0;
  localparam logic [3:0] IDX_COLON     = 4'd1;
  localparam logic [3:0] IDX_HEX_FIRST = 4'd2;
  localparam logic [3:0] IDX_HEX_LAST  = 4'd9;
  localparam logic [3:0] IDX_EOL_FIRST = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Uppercase ASCII hex digit for one nibble
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASCII_0 + {4'd0, n};
    else           return ASCII_A + {4'd0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_print_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first active
// request at or above ptr, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [N_REQ-1:0]   first_rot;
  logic [2*N_REQ-1:0] grant_dbl;

  // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back
  always_comb begin
    req_dbl   = {req, req} >> ptr;
    req_rot   = req_dbl[N_REQ-1:0];
    first_rot = req_rot & (~req_rot + N_REQ'(1));
    grant_dbl = {{N_REQ{1'b0}}, first_rot} << ptr;
    grant     = grant_dbl[N_REQ-1:0] | grant_dbl[2*N_REQ-1:N_REQ];
  end

endmodule

// File: rtl/uart_print_ctrl.sv
// Shares one UART byte transmitter among N_REQ requesters. Each grant
// prints "<tag>:<8 hex digits><EOL>" from a value latched at grant time.
module uart_print_ctrl
  import uart_print_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int EOL_CRLF = 1
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic [N_REQ-1:0]    I_req,
  input  logic [8*N_REQ-1:0]  I_tag,
  input  logic [32*N_REQ-1:0] I_value,
  output logic [N_REQ-1:0]    O_ack,
  output logic [7:0]          O_tx_data,
  output logic                O_tx_valid,
  input  logic                I_tx_ready,
  output logic                O_busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int FRAME_LEN = (EOL_CRLF != 0) ? FRAME_LEN_CRLF : FRAME_LEN_LF;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  state_e           state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt, grant_idx;
  logic [N_REQ-1:0] grant, ack_q;
  logic [7:0]       sel_tag, tag_q, tx_byte;
  logic [31:0]      sel_val, val_q, val_sh;
  logic [3:0]       byte_idx, nib_pos;
  logic             last_accept;

  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req   (I_req),
    .ptr   (ptr),
    .grant (grant)
  );

  // Decode the one-hot grant into an index and pick that requester's fields
  always_comb begin
    grant_idx = '0;
    sel_tag   = '0;
    sel_val   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = PTR_W'(i);
        sel_tag   = I_tag[8*i +: 8];
        sel_val   = I_value[32*i +: 32];
      end
    end
  end

  assign ptr_nxt     = (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
  assign last_accept = (byte_idx == LAST_IDX) && I_tx_ready;

  // State register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state: leave IDLE on any request, return when the last byte goes
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|I_req)      state_nxt = ST_SEND;
      ST_SEND: if (last_accept) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Grant latching, ack pulse, pointer update and byte sequencing
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      ptr      <= '0;
      ack_q    <= '0;
      tag_q    <= '0;
      val_q    <= '0;
      byte_idx <= '0;
    end else begin
      ack_q <= '0;
      if (state == ST_IDLE) begin
        byte_idx <= '0;
        if (|I_req) begin
          ack_q <= grant;
          tag_q <= sel_tag;
          val_q <= sel_val;
          ptr   <= ptr_nxt;
        end
      end else if (I_tx_ready) begin
        byte_idx <= (byte_idx == LAST_IDX) ? 4'd0 : byte_idx + 4'd1;
      end
    end
  end

  // Hex digit k of the frame is nibble k of the value, MSB first
  assign nib_pos = byte_idx - IDX_HEX_FIRST;
  assign val_sh  = val_q << {nib_pos[2:0], 2'b00};

  // Frame byte for the current index
  always_comb begin
    tx_byte = 8'h00;
    if (byte_idx == IDX_TAG)            tx_byte = tag_q;
    else if (byte_idx == IDX_COLON)     tx_byte = ASCII_COLON;
    else if (byte_idx <= IDX_HEX_LAST)  tx_byte = hex_ascii(val_sh[31:28]);
    else if (byte_idx == IDX_EOL_FIRST) tx_byte = (EOL_CRLF != 0) ? ASCII_CR : ASCII_LF;
    else                                tx_byte = ASCII_LF;
  end

  // Outputs decoded from state; data forced to zero outside SEND
  always_comb begin
    O_busy     = (state != ST_IDLE);
    O_tx_valid = (state == ST_SEND);
    O_tx_data  = (state == ST_SEND) ? tx_byte : 8'h00;
  end

  assign O_ack = ack_q;

endmodule

// File: tb/tb_uart_print_ctrl.sv
// Bench for uart_print_ctrl: directed frames plus random traffic, all
// checked against a transaction-level model of frames and arbitration.
module tb_uart_print_ctrl;

  localparam int N = 4;

  logic              I_clk = 1'b0;
  logic              I_rst_n = 1'b1;
  logic [N-1:0]      I_req = '0;
  logic [8*N-1:0]    I_tag = '0;
  logic [32*N-1:0]   I_value = '0;
  logic [N-1:0]      O_ack;
  logic [7:0]        O_tx_data;
  logic              O_tx_valid;
  logic              I_tx_ready = 1'b1;
  logic              O_busy;

  logic [N-1:0]      lf_req = '0;
  logic [8*N-1:0]    lf_tag = '0;
  logic [32*N-1:0]   lf_value = '0;
  logic [N-1:0]      lf_ack;
  logic [7:0]        lf_data;
  logic              lf_valid;
  logic              lf_ready = 1'b1;
  logic              lf_busy;

  uart_print_ctrl #(.N_REQ(N), .EOL_CRLF(1)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_req(I_req), .I_tag(I_tag),
    .I_value(I_value), .O_ack(O_ack), .O_tx_data(O_tx_data),
    .O_tx_valid(O_tx_valid), .I_tx_ready(I_tx_ready), .O_busy(O_busy)
  );

  uart_print_ctrl #(.N_REQ(N), .EOL_CRLF(0)) dut_lf (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_req(lf_req), .I_tag(lf_tag),
    .I_value(lf_value), .O_ack(lf_ack), .O_tx_data(lf_data),
    .O_tx_valid(lf_valid), .I_tx_ready(lf_ready), .O_busy(lf_busy)
  );

  always #5 I_clk = ~I_clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: expected bytes of the frame in flight, send flag, last winner
  logic [7:0] q[$];
  logic [7:0] got[$];
  int         grant_log[$];
  bit         m_send = 0;
  bit         fin = 0;
  bit         hold_all = 0;
  int         last = N-1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int lst);
    for (int i = 1; i <= N; i++)
      if (r[(lst+i)%N]) return (lst+i)%N;
    return -1;
  endfunction

  task automatic push_frame(input logic [7:0] t, input logic [31:0] v);
    int n;
    q.push_back(t);
    q.push_back(8'h3A);
    for (int d = 7; d >= 0; d--) begin
      n = int'((v >> (4*d)) & 32'hF);
      q.push_back(n < 10 ? 8'(48 + n) : 8'(65 + n - 10));
    end
    q.push_back(8'h0D);
    q.push_back(8'h0A);
  endtask

  // One cycle: account for acceptance at the coming edge, then check
  // the outputs half a cycle later against the model.
  task automatic tick();
    int k;
    if (m_send && I_tx_ready && q.size() > 0) begin
      got.push_back(q.pop_front());
      if (q.size() == 0) fin = 1;
    end
    @(negedge I_clk);
    if (!m_send) begin
      if (I_req != '0) begin
        k = rr_pick(I_req, last);
        last = k;
        grant_log.push_back(k);
        push_frame(I_tag[8*k +: 8], I_value[32*k +: 32]);
        m_send = 1;
        chk("ack_grant", 32'(O_ack), 32'(1) << k);
        if (!hold_all) I_req[k] = 1'b0;
      end else begin
        chk("ack_idle", 32'(O_ack), 0);
      end
    end else begin
      if (fin) m_send = 0;
      chk("ack_send", 32'(O_ack), 0);
    end
    fin = 0;
    chk("tx_valid", 32'(O_tx_valid), 32'(m_send));
    chk("busy", 32'(O_busy), 32'(m_send));
    if (m_send) chk("tx_data", 32'(O_tx_data), 32'(q[0]));
    else        chk("tx_data_idle", 32'(O_tx_data), 0);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((m_send || I_req != '0) && n < max) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < max), 1);
  endtask

  task automatic do_reset();
    I_rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(O_tx_valid), 0);
    chk("rst_busy", 32'(O_busy), 0);
    chk("rst_ack", 32'(O_ack), 0);
    chk("rst_data", 32'(O_tx_data), 0);
    m_send = 0;
    fin = 0;
    q.delete();
    last = N-1;
    @(negedge I_clk);
    I_rst_n = 1'b1;
  endtask

  logic [7:0] exp31[12] = '{8'h46, 8'h3A, 8'h30, 8'h30, 8'h43, 8'h30,
                            8'h46, 8'h46, 8'h45, 8'h45, 8'h0D, 8'h0A};
  logic [7:0] lf_got[$];

  initial begin
    int n;
    int acks;
    #1;
    do_reset();

    // Single request, ready always high
    I_tag[7:0] = 8'h46;
    I_value[31:0] = 32'h00C0FFEE;
    I_tx_ready = 1'b1;
    I_req = 4'b0001;
    got.delete();
    drain(40);
    chk("f1_len", 32'(got.size()), 12);
    for (int i = 0; i < 12 && i < got.size(); i++)
      chk($sformatf("f1_byte%0d", i), 32'(got[i]), 32'(exp31[i]));

    // Value changes two cycles after ack must not reach the frame
    I_value[31:0] = 32'hAAAAAAAA;
    I_req = 4'b0001;
    got.delete();
    tick();
    tick();
    tick();
    I_value[31:0] = 32'h55555555;
    drain(40);
    chk("vchg_len", 32'(got.size()), 12);
    for (int i = 2; i < 10 && i < got.size(); i++)
      chk($sformatf("vchg_digit%0d", i), 32'(got[i]), 32'h41);

    // Backpressure: ready pattern 1,0,0 repeating
    I_value[31:0] = 32'h12345678;
    I_req = 4'b0001;
    got.delete();
    n = 0;
    while ((m_send || I_req != '0) && n < 100) begin
      I_tx_ready = (n % 3 == 0);
      tick();
      n++;
    end
    chk("bp_timeout", 32'(n < 100), 1);
    I_tx_ready = 1'b1;
    chk("bp_len", 32'(got.size()), 12);
    for (int i = 2; i < 10 && i < got.size(); i++)
      chk($sformatf("bp_digit%0d", i), 32'(got[i]), 32'(8'h31 + 8'(i - 2)));

    // All requesters held: round-robin order from index 0 after reset
    do_reset();
    for (int k = 0; k < N; k++) begin
      I_tag[8*k +: 8] = 8'(8'h61 + k);
      I_value[32*k +: 32] = 32'h1000_0001 * (k + 1);
    end
    hold_all = 1;
    I_req = '1;
    grant_log.delete();
    n = 0;
    while (grant_log.size() < 5 && n < 100) begin
      tick();
      n++;
    end
    chk("rr_timeout", 32'(n < 100), 1);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      chk($sformatf("rr_order%0d", i), 32'(grant_log[i]), 32'(i % N));
    hold_all = 0;
    I_req = '0;
    drain(40);

    // Reset after the fifth byte, request still held
    I_tag[23:16] = 8'h5A;
    I_req = 4'b0100;
    got.delete();
    n = 0;
    while (got.size() < 5 && n < 40) begin
      tick();
      n++;
    end
    chk("mid_timeout", 32'(n < 40), 1);
    I_req[2] = 1'b1;
    do_reset();
    got.delete();
    drain(40);
    chk("mid_len", 32'(got.size()), 12);
    if (got.size() > 0) chk("mid_first", 32'(got[0]), 32'h5A);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!I_req[k] && $urandom_range(0, 5) == 0) I_req[k] = 1'b1;
        else if (I_req[k] && $urandom_range(0, 60) == 0) I_req[k] = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          I_tag[8*k +: 8] = 8'($urandom_range(33, 126));
          I_value[32*k +: 32] = $urandom;
        end
      end
      I_tx_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    I_req = '0;
    I_tx_ready = 1'b1;
    drain(60);

    // LF-only instance: 11-byte frame
    lf_tag[7:0] = 8'h46;
    lf_value[31:0] = 32'hFFFFFFFF;
    lf_req = 4'b0001;
    acks = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge I_clk);
      if (lf_ack != '0) begin
        acks++;
        chk("lf_ack", 32'(lf_ack), 1);
        lf_req = '0;
      end
      if (lf_valid) lf_got.push_back(lf_data);
    end
    chk("lf_acks", 32'(acks), 1);
    chk("lf_len", 32'(lf_got.size()), 11);
    if (lf_got.size() == 11) begin
      chk("lf_tag", 32'(lf_got[0]), 32'h46);
      chk("lf_colon", 32'(lf_got[1]), 32'h3A);
      chk("lf_m2", 32'(lf_got[8]), 32'h46);
      chk("lf_m1", 32'(lf_got[9]), 32'h46);
      chk("lf_eol", 32'(lf_got[10]), 32'h0A);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
